// File: rtl/timer_mc.sv
// Multi-channel APB timer: NUM_CH up-counters sharing one prescaler, with per-channel
// compare, auto-reload and maskable interrupt. Each APB transfer takes exactly one wait state.
module timer_mc #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned DIV_W  = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              tim_psel,
  input  logic              tim_penable,
  input  logic              tim_pwrite,
  input  logic [11:0]       tim_paddr,
  input  logic [31:0]       tim_pwdata,
  input  logic [3:0]        tim_pstrb,
  output logic [31:0]       tim_prdata,
  output logic              tim_pready,
  output logic              tim_pslverr,
  input  logic              dbg_mode,
  output logic [NUM_CH-1:0] tim_irq,
  output logic              tim_int
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSetup  = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;
  localparam logic [1:0] StAccess = 2'd3;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [1:0]       state_q, state_d, phase;
  logic             access, wr_en;
  logic [31:0]      wmask, rd;
  logic             sel_gcr, sel_gsts, sel_halt, ch_space;
  logic [NUM_CH-1:0] ch_sel;

  logic             gen_q, gen_d, den_q, den_d, hreq_q, hreq_d;
  logic [DIV_W-1:0] dval_q, dval_d, div_q, div_d;
  logic             halt_ack, run, tick;

  logic [NUM_CH-1:0] en_q, en_d, ar_q, ar_d, ie_q, ie_d, ist_q, ist_d, irq_q;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  cmp_q [NUM_CH];
  logic [CNT_W-1:0]  cmp_d [NUM_CH];

  // SETUP is never stored: it is the IDLE cycle in which a new transfer is seen.
  always_comb begin
    phase = state_q;
    if (state_q == StIdle && tim_psel && !tim_penable) phase = StSetup;
    state_d = StIdle;
    case (phase)
      StSetup:  state_d = StWait;
      StWait:   state_d = (tim_psel && tim_penable) ? StAccess : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign access      = (state_q == StAccess);
  assign wr_en       = access & tim_psel & tim_pwrite;
  assign tim_pready  = access;
  assign tim_pslverr = 1'b0;

  always_comb begin
    for (int b = 0; b < 4; b++) wmask[b*8 +: 8] = {8{tim_pstrb[b]}};
  end

  assign sel_gcr  = (tim_paddr[11:2] == 10'h000);
  assign sel_gsts = (tim_paddr[11:2] == 10'h001);
  assign sel_halt = (tim_paddr[11:2] == 10'h002);
  assign ch_space = (tim_paddr[11:8] == 4'h1);

  always_comb begin
    for (int n = 0; n < NUM_CH; n++) ch_sel[n] = ch_space && (tim_paddr[7:4] == 4'(n));
  end

  assign halt_ack = hreq_q & dbg_mode;
  assign run      = gen_q & ~halt_ack;
  assign tick     = run & (~den_q | (div_q == dval_q));

  always_comb begin
    gen_d  = gen_q;
    den_d  = den_q;
    dval_d = dval_q;
    hreq_d = hreq_q;
    div_d  = div_q;
    if (wr_en && sel_gcr) begin
      if (tim_pstrb[0]) begin
        gen_d = tim_pwdata[0];
        den_d = tim_pwdata[1];
      end
      if (tim_pstrb[1]) dval_d = tim_pwdata[8 +: DIV_W];
      div_d = '0;
    end else if (run) begin
      div_d = (div_q == dval_q) ? '0 : div_q + DIV_W'(1);
    end
    if (wr_en && sel_halt && tim_pstrb[0]) hreq_d = tim_pwdata[0];
  end

  always_comb begin
    en_d  = en_q;
    ar_d  = ar_q;
    ie_d  = ie_q;
    ist_d = ist_q;
    for (int n = 0; n < NUM_CH; n++) begin
      cnt_d[n] = cnt_q[n];
      cmp_d[n] = cmp_q[n];
      if (wr_en && ch_sel[n] && tim_paddr[3:2] == 2'd0 && tim_pstrb[0]) begin
        en_d[n] = tim_pwdata[0];
        ar_d[n] = tim_pwdata[1];
        ie_d[n] = tim_pwdata[2];
      end
      if (wr_en && ch_sel[n] && tim_paddr[3:2] == 2'd2) begin
        cmp_d[n] = CNT_W'((32'(cmp_q[n]) & ~wmask) | (tim_pwdata & wmask));
      end
      if (wr_en && ch_sel[n] && tim_paddr[3:2] == 2'd1) begin
        cnt_d[n] = CNT_W'((32'(cnt_q[n]) & ~wmask) | (tim_pwdata & wmask));
      end else if (tick && en_q[n]) begin
        cnt_d[n] = (ar_q[n] && cnt_q[n] == cmp_q[n]) ? '0 : cnt_q[n] + CntOne;
      end
      // Match has priority over a same-cycle write-1-to-clear.
      ist_d[n] = (en_q[n] & gen_q & (cnt_q[n] == cmp_q[n])) |
                 (ist_q[n] & ~(wr_en & ch_sel[n] & (tim_paddr[3:2] == 2'd3) &
                               tim_pstrb[0] & tim_pwdata[0]));
    end
  end

  always_comb begin
    rd = '0;
    if (sel_gcr) begin
      rd[0]          = gen_q;
      rd[1]          = den_q;
      rd[8 +: DIV_W] = dval_q;
    end
    if (sel_gsts) rd[NUM_CH-1:0] = ist_q;
    if (sel_halt) rd[1:0] = {halt_ack, hreq_q};
    for (int n = 0; n < NUM_CH; n++) begin
      if (ch_sel[n]) begin
        case (tim_paddr[3:2])
          2'd0:    rd[2:0] = {ie_q[n], ar_q[n], en_q[n]};
          2'd1:    rd[CNT_W-1:0] = cnt_q[n];
          2'd2:    rd[CNT_W-1:0] = cmp_q[n];
          default: rd[0] = ist_q[n];
        endcase
      end
    end
  end

  assign tim_prdata = access ? rd : 32'h0;
  assign tim_irq    = irq_q;
  assign tim_int    = |irq_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
      gen_q   <= 1'b0;
      den_q   <= 1'b0;
      dval_q  <= '0;
      div_q   <= '0;
      hreq_q  <= 1'b0;
      en_q    <= '0;
      ar_q    <= '0;
      ie_q    <= '0;
      ist_q   <= '0;
      irq_q   <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        cnt_q[n] <= '0;
        cmp_q[n] <= '1;
      end
    end else begin
      state_q <= state_d;
      gen_q   <= gen_d;
      den_q   <= den_d;
      dval_q  <= dval_d;
      div_q   <= div_d;
      hreq_q  <= hreq_d;
      en_q    <= en_d;
      ar_q    <= ar_d;
      ie_q    <= ie_d;
      ist_q   <= ist_d;
      irq_q   <= ist_d & ie_d;
      for (int n = 0; n < NUM_CH; n++) begin
        cnt_q[n] <= cnt_d[n];
        cmp_q[n] <= cmp_d[n];
      end
    end
  end

endmodule

// File: tb/tb_timer_mc.sv
// Bench for timer_mc: directed scenarios then random APB traffic, all checked against a
// cycle-level behavioural model of the register map, prescaler and channels.
module tb_timer_mc;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int DIV_W  = 4;
  localparam longint unsigned CntMod = 64'd1 << CNT_W;
  localparam logic [31:0] CntMask = 32'(CntMod - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0] pstrb = '0;
  logic [31:0] prdata;
  logic pready, pslverr;
  logic dbg = 1'b0;
  logic [NUM_CH-1:0] irq;
  logic tint;

  always #5 clk = ~clk;

  timer_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .sys_clk(clk), .sys_rst(rst), .tim_psel(psel), .tim_penable(penable),
    .tim_pwrite(pwrite), .tim_paddr(paddr), .tim_pwdata(pwdata), .tim_pstrb(pstrb),
    .tim_prdata(prdata), .tim_pready(pready), .tim_pslverr(pslverr), .dbg_mode(dbg),
    .tim_irq(irq), .tim_int(tint)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural model state
  bit m_gen, m_den, m_hreq;
  logic [DIV_W-1:0] m_dval;
  longint unsigned m_div;  // running cycles since last prescaler clear
  logic [31:0] m_cnt [NUM_CH];
  logic [31:0] m_cmp [NUM_CH];
  bit m_en [NUM_CH];
  bit m_ar [NUM_CH];
  bit m_ie [NUM_CH];
  bit m_ist [NUM_CH];

  bit acc_wr = 0;
  logic [11:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0] acc_strb;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r & CntMask;
  endfunction

  task automatic m_reset();
    m_gen = 0; m_den = 0; m_hreq = 0; m_dval = '0; m_div = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_cnt[c] = 0; m_cmp[c] = CntMask; m_en[c] = 0; m_ar[c] = 0; m_ie[c] = 0; m_ist[c] = 0;
    end
  endtask

  function automatic bit is_ch(input int a);
    return a >= 'h100 && a < 'h100 + 16 * NUM_CH && a % 4 == 0;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    logic [31:0] r = 0;
    if (a == 0) begin
      r[0] = m_gen; r[1] = m_den; r[8 +: DIV_W] = m_dval;
    end else if (a == 4) begin
      for (int c = 0; c < NUM_CH; c++) r[c] = m_ist[c];
    end else if (a == 8) begin
      r[0] = m_hreq; r[1] = m_hreq && dbg;
    end else if (is_ch(a)) begin
      int c = (a - 'h100) / 16;
      case (a % 16)
        0: r = {29'b0, m_ie[c], m_ar[c], m_en[c]};
        4: r = m_cnt[c];
        8: r = m_cmp[c];
        default: r = {31'b0, m_ist[c]};
      endcase
    end
    return r;
  endfunction

  // Advance model and DUT by one clock, then compare the interrupt outputs.
  task automatic step();
    logic [NUM_CH-1:0] e;
    if (rst) begin
      @(posedge clk); #1;
      m_reset();
    end else begin
      bit halted = m_hreq && dbg;
      bit running = m_gen && !halted;
      bit tk = running && (!m_den || (m_div % (m_dval + 1)) == m_dval);
      bit n_gen = m_gen, n_den = m_den, n_hreq = m_hreq;
      logic [DIV_W-1:0] n_dval = m_dval;
      longint unsigned n_div = running ? m_div + 1 : m_div;
      logic [31:0] n_cnt [NUM_CH];
      logic [31:0] n_cmp [NUM_CH];
      bit n_en [NUM_CH], n_ar [NUM_CH], n_ie [NUM_CH], n_ist [NUM_CH];
      int a = int'(acc_addr);
      for (int c = 0; c < NUM_CH; c++) begin
        bit match = m_en[c] && m_gen && m_cnt[c] == m_cmp[c];
        bit w1c = 0, cwr = 0;
        n_cmp[c] = m_cmp[c]; n_en[c] = m_en[c]; n_ar[c] = m_ar[c]; n_ie[c] = m_ie[c];
        if (acc_wr && is_ch(a) && (a - 'h100) / 16 == c) begin
          case (a % 16)
            0: if (acc_strb[0]) begin
                 n_en[c] = acc_wdata[0]; n_ar[c] = acc_wdata[1]; n_ie[c] = acc_wdata[2];
               end
            4: cwr = 1;
            8: n_cmp[c] = merge(m_cmp[c], acc_wdata, acc_strb);
            default: w1c = acc_strb[0] && acc_wdata[0];
          endcase
        end
        n_ist[c] = match || (m_ist[c] && !w1c);
        if (cwr) n_cnt[c] = merge(m_cnt[c], acc_wdata, acc_strb);
        else if (tk && m_en[c])
          n_cnt[c] = (m_ar[c] && m_cnt[c] == m_cmp[c]) ? 0 : 32'((m_cnt[c] + 64'd1) % CntMod);
        else n_cnt[c] = m_cnt[c];
      end
      if (acc_wr && a == 0) begin
        if (acc_strb[0]) begin n_gen = acc_wdata[0]; n_den = acc_wdata[1]; end
        if (acc_strb[1]) n_dval = acc_wdata[8 +: DIV_W];
        n_div = 0;
      end
      if (acc_wr && a == 8 && acc_strb[0]) n_hreq = acc_wdata[0];
      @(posedge clk); #1;
      m_gen = n_gen; m_den = n_den; m_dval = n_dval; m_div = n_div; m_hreq = n_hreq;
      for (int c = 0; c < NUM_CH; c++) begin
        m_cnt[c] = n_cnt[c]; m_cmp[c] = n_cmp[c]; m_en[c] = n_en[c];
        m_ar[c] = n_ar[c]; m_ie[c] = n_ie[c]; m_ist[c] = n_ist[c];
      end
    end
    for (int c = 0; c < NUM_CH; c++) e[c] = m_ist[c] && m_ie[c];
    check("tim_irq", 32'(irq), 32'(e));
    check("tim_int", 32'(tint), 32'(|e));
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic apb(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                     input logic [3:0] st, output logic [31:0] rd);
    psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
    #1;
    check("pready_setup", 32'(pready), 0);
    step();
    penable = 1;
    #1;
    check("pready_wait", 32'(pready), 0);
    step();
    check("pready_access", 32'(pready), 1);
    check("pslverr", 32'(pslverr), 0);
    rd = prdata;
    if (!wr) check($sformatf("read_%03h", addr), prdata, m_read(int'(addr)));
    acc_wr = wr; acc_addr = addr; acc_wdata = wd; acc_strb = st;
    step();
    acc_wr = 0;
    psel = 0; penable = 0; pwrite = 0;
    #1;
    check("prdata_idle", prdata, 0);
  endtask

  task automatic wr32(input logic [11:0] addr, input logic [31:0] wd);
    logic [31:0] d;
    apb(1, addr, wd, 4'hF, d);
  endtask

  task automatic rd32(input logic [11:0] addr, output logic [31:0] d);
    apb(0, addr, 32'h0, 4'h0, d);
  endtask

  logic [31:0] d;
  logic [11:0] ra;

  initial begin
    m_reset();
    step(); step();
    rst = 0;
    check("rst_pready", 32'(pready), 0);
    check("rst_prdata", prdata, 0);

    // Reset values of every mapped register
    rd32(12'h000, d); check("rst_gcr", d, 0);
    rd32(12'h004, d); check("rst_gsts", d, 0);
    rd32(12'h008, d); check("rst_halt", d, 0);
    for (int c = 0; c < NUM_CH; c++) begin
      for (int r = 0; r < 4; r++) begin
        ra = 12'('h100 + 16 * c + 4 * r);
        rd32(ra, d);
        check($sformatf("rst_ch%0d_r%0d", c, r), d, (r == 2) ? 32'hFFFF_FFFF : 32'h0);
      end
    end

    // Unmapped and out-of-range channel slots
    wr32(12'h1AA, 32'h1234_ABCD);
    rd32(12'h1AA, d); check("unmapped_1aa", d, 0);
    ra = 12'('h100 + 16 * NUM_CH);
    wr32(ra, 32'h1234_ABCD);
    rd32(ra, d); check("unmapped_ch", d, 0);

    // Channel 0 counting to compare
    wr32(12'h108, 5);
    wr32(12'h100, 5);
    wr32(12'h000, 1);
    idle(3);
    rd32(12'h104, d);
    rd32(12'h10C, d);
    // Held match under debug halt: clear loses to the persisting match
    dbg = 1;
    wr32(12'h008, 1);
    wr32(12'h104, 5);
    idle(2);
    wr32(12'h10C, 1);
    rd32(12'h10C, d); check("w1c_vs_match", d, 1);
    check("irq0_held", 32'(irq[0]), 1);
    rd32(12'h008, d); check("halt_ack", d, 3);
    dbg = 0;
    wr32(12'h008, 0);
    wr32(12'h100, 0);

    // Channel 1 auto-reload with divide-by-4
    wr32(12'h118, 2);
    wr32(12'h114, 0);
    wr32(12'h110, 7);
    wr32(12'h000, 32'h0303);
    for (int i = 0; i < 6; i++) begin
      rd32(12'h114, d);
      rd32(12'h11C, d);
      wr32(12'h11C, 1);
    end
    wr32(12'h110, 0);

    // Channel 2 wrap at the top of the range, then a CNT write on a tick cycle
    wr32(12'h000, 0);
    wr32(12'h124, 32'hFFFF_FFFF);
    wr32(12'h128, 0);
    wr32(12'h120, 5);
    wr32(12'h000, 1);
    idle(2);
    rd32(12'h124, d);
    rd32(12'h12C, d);
    wr32(12'h124, 7);
    rd32(12'h124, d); check("cnt_load_wins", d, 9);

    // Debug halt freezes counting; release resumes
    dbg = 1;
    wr32(12'h008, 1);
    rd32(12'h124, d);
    idle(10);
    rd32(12'h124, d);
    dbg = 0;
    idle(5);
    rd32(12'h124, d);
    wr32(12'h008, 0);

    // Reset mid-transfer
    psel = 1; penable = 0; pwrite = 1; paddr = 12'h128; pwdata = 32'h55; pstrb = 4'hF;
    step();
    penable = 1;
    rst = 1;
    step();
    rst = 0; psel = 0; penable = 0; pwrite = 0;
    #1;
    check("rst_mid_pready", 32'(pready), 0);
    rd32(12'h128, d); check("rst_mid_cmp", d, 32'hFFFF_FFFF);
    rd32(12'h000, d); check("rst_mid_gcr", d, 0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      int sel = $urandom_range(0, 9);
      int c = $urandom_range(0, NUM_CH - 1);
      int r = $urandom_range(0, 3);
      bit w = $urandom_range(0, 1);
      logic [31:0] v = $urandom_range(0, 12);
      logic [3:0] st = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 15) == 0) dbg = ~dbg;
      case (sel)
        0: begin
             ra = 12'h000;
             v = {20'b0, 4'($urandom_range(0, 3)), 6'b0, 1'($urandom), 1'($urandom_range(0, 3) != 0)};
           end
        1: ra = 12'h004;
        2: begin ra = 12'h008; v = 32'($urandom_range(0, 3)); end
        3: begin ra = 12'h0FC; v = $urandom; end
        4: begin ra = 12'('h100 + 16 * NUM_CH + 4 * r); v = $urandom; end
        default: begin
             ra = 12'('h100 + 16 * c + 4 * r);
             if (r == 0) v = 32'($urandom_range(0, 7));
             if (r == 1 && $urandom_range(0, 7) == 0) v = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
           end
      endcase
      apb(w, ra, v, st, d);
      idle($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_mc.md
Name: timer_mc

Overview:
- Parametrised multi-channel successor to the single 64-bit APB timer.
- NUM_CH independent up-counters share one global prescaler. Each channel has its own compare register, auto-reload mode and maskable interrupt.
- Debug halt is shared across all channels.
- Sits on the APB peripheral bus. Drives per-channel IRQs plus one combined interrupt to the interrupt controller.

Parameters:
- NUM_CH, 4, number of channels; legal range 1..16.
- CNT_W, 32, counter/compare width in bits; legal range 8..32. Register bits above CNT_W read 0 and ignore writes.
- DIV_W, 4, width of the prescaler divide field.

Ports:
- sys_clk  in  1  single clock for all logic.
- sys_rst  in  1  synchronous, active-high reset.
- tim_psel  in  1  APB select.
- tim_penable  in  1  APB enable.
- tim_pwrite  in  1  APB write.
- tim_paddr  in  12  APB byte address.
- tim_pwdata  in  32  write data.
- tim_pstrb  in  4  byte strobes.
- tim_prdata  out  32  read data.
- tim_pready  out  1  transfer complete.
- tim_pslverr  out  1  always 0.
- dbg_mode  in  1  debugger attached.
- tim_irq  out  NUM_CH  per-channel interrupt.
- tim_int  out  1  OR of tim_irq.

Behaviour:
- Interface: one clock, sys_clk; reset sys_rst is synchronous and active-high. All registers clear on the sys_clk edge where sys_rst=1, including mid-transfer; the APB FSM returns to IDLE.
- Reset values: tim_prdata=0, tim_pready=0, tim_pslverr=0, tim_irq=0, tim_int=0, all CNT=0, all CMP=all-ones, all CTRL/STS/GCR/HALT=0.
- APB FSM states:
  - IDLE.
  - SETUP: psel & !penable.
  - WAIT: first penable cycle; pready=0.
  - ACCESS: pready=1 for exactly one cycle, then IDLE.
  - Each transfer therefore has exactly one wait state.
- Writes commit and tim_prdata is valid in the ACCESS cycle. tim_prdata=0 outside ACCESS.
- pstrb is honoured per byte on every RW register.
- Reserved or unmapped addresses, including channel slots >= NUM_CH: reads return 0, writes are ignored, no error.
- Register map:
  - 0x000 GCR: [0] global_en; [1] div_en; [8+:DIV_W] div_val. Any write clears the prescaler counter.
  - 0x004 GSTS: RO; [NUM_CH-1:0] = STS.int_st of every channel.
  - 0x008 HALT: [0] halt_req RW; [1] halt_ack RO, equal to halt_req & dbg_mode.
  - 0x100 + 0x10*n, channel n:
    - +0x0 CTRL: [0] ch_en; [1] auto_reload; [2] int_en.
    - +0x4 CNT: RW.
    - +0x8 CMP: RW.
    - +0xC STS: [0] int_st, write-1-to-clear.
- Prescaler and tick:
  - tick = global_en & !halt_ack & (div_en ? div_cnt==div_val : 1).
  - div_cnt runs 0..div_val, then wraps to 0. It counts only while global_en & !halt_ack, and holds while halted.
  - div_val=0 with div_en=1 gives a tick every cycle.
- Channel n counter update, in priority order:
  1. APB write to CNT loads the written bytes; this wins over a tick.
  2. Otherwise, on tick & ch_en: if auto_reload & CNT==CMP, CNT<=0; else CNT<=CNT+1, wrapping from 2^CNT_W-1 to 0.
- Match: int_st is set in every cycle where ch_en & global_en & CNT==CMP. This is level-based, so int_st re-sets after a clear while the match persists.
- A set from match and a W1C in the same cycle: set wins.
- Writing CMP equal to the current CNT sets int_st on the next cycle.
- tim_irq[n] = int_st[n] & int_en[n], registered so it follows int_st by 0 cycles. tim_int = |tim_irq.
- Disabling a channel freezes CNT and keeps int_st.
- Clearing global_en freezes all counters and the prescaler. It does not clear them.
- Halt: while halt_ack=1, no ticks occur. APB access stays fully functional.

Test Plan:
- Reset, then read all mapped registers -> CMP=0xFFFF_FFFF (CNT_W=32); every other register 0; every read completes in 3 cycles (SETUP, WAIT, ACCESS).
- Write 0x4000_01AA and channel offset 0x100+0x10*NUM_CH with 0x1234_ABCD, then read back -> 0 both times; tim_pslverr=0.
- Channel 0: CMP=5, CTRL=0x5, GCR=0x1 -> CNT reaches 5 after 5 cycles; tim_irq[0]=1 and tim_int=1; W1C to STS while CNT stays 5 -> int_st remains 1.
- Channel 1: auto_reload, CMP=2, GCR=0x0303 (div_en, div_val=3) -> CNT sequence 0,1,2,0,… stepping every 4 cycles; int_st set at each CNT=2.
- CNT=0xFFFF_FFFF, ch_en, CMP=0 -> wraps to 0 on next tick; int_st sets; write CNT=7 on a tick cycle -> CNT=7.
- HALT=1 with dbg_mode=1 -> halt_ack=1 and counters frozen for 10 cycles; dbg_mode=0 -> counting resumes from the held value; pulse sys_rst mid-transfer -> pready=0 and all registers at reset values next cycle.
